// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: instruction-memory req/ack, datapath valid/ready,
// redirect input and misalignment flag.
interface instr_fetch_unit_if #(
    parameter int IMEM_AW = 5
);
    logic               imem_req;
    logic [IMEM_AW-1:0] imem_addr;
    logic               imem_ack;
    logic [31:0]        imem_data;
    logic               redirect_valid;
    logic [31:0]        redirect_pc;
    logic               inst_valid;
    logic [31:0]        inst_data;
    logic [31:0]        inst_pc;
    logic               inst_ready;
    logic               misalign_err;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_data,
        input  redirect_valid, redirect_pc,
        output inst_valid, inst_data, inst_pc,
        input  inst_ready,
        output misalign_err
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_data,
        output redirect_valid, redirect_pc,
        input  inst_valid, inst_data, inst_pc,
        output inst_ready,
        input  misalign_err
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, fetches over a variable-latency
// req/ack memory port and hands instructions on via valid/ready.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 5
) (
    input logic                clk,
    input logic                rst,
    instr_fetch_unit_if.master bus
);
    typedef enum logic [1:0] {FETCH, OUT, DISCARD} state_t;

    state_t             state;
    logic [31:0]        pc;
    logic [IMEM_AW-1:0] req_addr;
    logic [31:0]        inst_data_q;
    logic [31:0]        inst_pc_q;
    logic               misalign_q;

    logic        ack;
    logic        redir;
    logic [31:0] target;

    assign target = {bus.redirect_pc[31:2], 2'b00};
    assign redir  = bus.redirect_valid;

    // Gating with rst keeps the request low for every reset cycle,
    // not just after the first reset edge.
    assign bus.imem_req     = !rst && (state != OUT);
    assign ack              = bus.imem_ack && bus.imem_req;
    assign bus.imem_addr    = req_addr;
    assign bus.inst_valid   = !rst && (state == OUT);
    assign bus.inst_data    = inst_data_q;
    assign bus.inst_pc      = inst_pc_q;
    assign bus.misalign_err = misalign_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            req_addr    <= RESET_PC[IMEM_AW+1:2];
            inst_data_q <= 32'h0;
            inst_pc_q   <= 32'h0;
            misalign_q  <= 1'b0;
        end else begin
            misalign_q <= redir && (bus.redirect_pc[1:0] != 2'b00);
            unique case (state)
                FETCH: begin
                    if (ack && redir) begin
                        pc       <= target;
                        req_addr <= target[IMEM_AW+1:2];
                    end else if (ack) begin
                        inst_data_q <= bus.imem_data;
                        inst_pc_q   <= pc;
                        pc          <= pc + 32'd4;
                        state       <= OUT;
                    end else if (redir) begin
                        // request stays live at req_addr until acked
                        pc    <= target;
                        state <= DISCARD;
                    end
                end
                DISCARD: begin
                    if (ack) begin
                        state <= FETCH;
                        if (redir) begin
                            pc       <= target;
                            req_addr <= target[IMEM_AW+1:2];
                        end else begin
                            req_addr <= pc[IMEM_AW+1:2];
                        end
                    end else if (redir) begin
                        pc <= target;
                    end
                end
                OUT: begin
                    if (redir || bus.inst_ready) begin
                        state <= FETCH;
                        if (redir) begin
                            pc       <= target;
                            req_addr <= target[IMEM_AW+1:2];
                        end else begin
                            req_addr <= pc[IMEM_AW+1:2];
                        end
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed per-cycle vectors,
// expected transfers queued, monitor pops on each accepted instruction.
module tb_instr_fetch_unit;
    logic clk;
    logic rst;

    instr_fetch_unit_if #(.IMEM_AW(5)) bus ();
    instr_fetch_unit_if #(.IMEM_AW(5)) bus2 ();

    instr_fetch_unit #(
        .RESET_PC(32'h0000_0000),
        .IMEM_AW(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    instr_fetch_unit #(
        .RESET_PC(32'hFFFF_FFFC),
        .IMEM_AW(5)
    ) dut_wrap (
        .clk(clk),
        .rst(rst),
        .bus(bus2.master)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    logic auto_en = 1'b0;
    int   ack_dly = 0;
    logic man_ack = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.imem_data  = 32'h1000_0000 + 32'(bus.imem_addr);
    assign bus2.imem_data = 32'h1000_0000 + 32'(bus2.imem_addr);
    assign bus2.imem_ack  = bus2.imem_req;
    assign bus2.redirect_valid = 1'b0;
    assign bus2.redirect_pc    = 32'h0;
    assign bus2.inst_ready     = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] data);
        q.push_back({pc, data});
    endtask

    // memory model: either a fixed ack latency or a scripted ack
    initial begin
        int cnt;
        cnt = 0;
        bus.imem_ack = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (auto_en) begin
                if (bus.imem_req) begin
                    if (cnt == ack_dly) begin
                        bus.imem_ack = 1'b1;
                        cnt = 0;
                    end else begin
                        bus.imem_ack = 1'b0;
                        cnt++;
                    end
                end else begin
                    bus.imem_ack = 1'b0;
                    cnt = 0;
                end
            end else begin
                bus.imem_ack = man_ack;
                cnt = 0;
            end
        end
    end

    // monitor: every accepted instruction must match the queue head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst && bus.inst_valid && bus.inst_ready) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected: got pc %h data %h want none",
                             bus.inst_pc, bus.inst_data);
                end else begin
                    e = q.pop_front();
                    chk("sb_pc", bus.inst_pc, e.pc);
                    chk("sb_data", bus.inst_data, e.data);
                end
            end
        end
    end

    task automatic drv(input logic ack, input logic rv,
                       input logic [31:0] rpc, input logic rdy);
        @(negedge clk);
        rst = 1'b0;
        man_ack = ack;
        bus.redirect_valid = rv;
        bus.redirect_pc = rpc;
        bus.inst_ready = rdy;
        #2;
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1;
        man_ack = 1'b1;
        bus.redirect_valid = 1'b0;
        #2;
        chk("req_in_rst", 32'(bus.imem_req), 32'd0);
        @(negedge clk);
        man_ack = 1'b0;
        #2;
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_valid", 32'(bus.inst_valid), 32'd0);
        chk("rst_misalign", 32'(bus.misalign_err), 32'd0);
        chk("rst_inst_pc", bus.inst_pc, 32'd0);
        chk("rst_inst_data", bus.inst_data, 32'd0);
    endtask

    task automatic drain;
        int n;
        n = 0;
        while (q.size() != 0 && n < 40) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk("sb_drained", 32'(q.size()), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.inst_ready = 1'b0;

        // back-to-back fetch, ack in the first request cycle
        do_reset();
        auto_en = 1'b1;
        ack_dly = 0;
        for (int n = 0; n < 6; n++)
            push(32'(n * 4), 32'h1000_0000 + 32'(n));
        for (int i = 0; i < 12; i++) begin
            drv(1'b0, 1'b0, 32'h0, 1'b1);
            chk("alt_valid", 32'(bus.inst_valid), 32'(i % 2));
            if (i == 0) begin
                chk("first_req", 32'(bus.imem_req), 32'd1);
                chk("first_addr", 32'(bus.imem_addr), 32'd0);
                chk("wrap_addr", 32'(bus2.imem_addr), 32'd31);
            end
            if (i == 1) begin
                chk("wrap_pc0", bus2.inst_pc, 32'hFFFF_FFFC);
                chk("wrap_data0", bus2.inst_data, 32'h1000_001F);
            end
            if (i == 3) begin
                chk("wrap_pc1", bus2.inst_pc, 32'h0);
                chk("wrap_data1", bus2.inst_data, 32'h1000_0000);
            end
        end
        chk("sb_empty1", 32'(q.size()), 32'd0);

        // slow memory and a stalled datapath
        do_reset();
        ack_dly = 3;
        push(32'h0, 32'h1000_0000);
        push(32'h4, 32'h1000_0001);
        for (int i = 0; i < 4; i++) begin
            drv(1'b0, 1'b0, 32'h0, 1'b0);
            chk("wait_req", 32'(bus.imem_req), 32'd1);
            chk("wait_addr", 32'(bus.imem_addr), 32'd0);
        end
        for (int i = 0; i < 4; i++) begin
            drv(1'b0, 1'b0, 32'h0, 1'b0);
            chk("stall_valid", 32'(bus.inst_valid), 32'd1);
            chk("stall_req", 32'(bus.imem_req), 32'd0);
            chk("stall_pc", bus.inst_pc, 32'h0);
            chk("stall_data", bus.inst_data, 32'h1000_0000);
        end
        drv(1'b0, 1'b0, 32'h0, 1'b1);
        drain();

        // redirect while the request to 8 is in flight
        do_reset();
        auto_en = 1'b0;
        push(32'h0, 32'h1000_0000);
        push(32'h4, 32'h1000_0001);
        push(32'h40, 32'h1000_0010);
        drv(1'b1, 1'b0, 32'h0, 1'b1);
        drv(1'b0, 1'b0, 32'h0, 1'b1);
        drv(1'b1, 1'b0, 32'h0, 1'b1);
        drv(1'b0, 1'b0, 32'h0, 1'b1);
        drv(1'b0, 1'b0, 32'h0, 1'b1);
        chk("req8_addr", 32'(bus.imem_addr), 32'd2);
        drv(1'b0, 1'b1, 32'h40, 1'b1);
        chk("redir_addr_hold", 32'(bus.imem_addr), 32'd2);
        drv(1'b0, 1'b0, 32'h0, 1'b1);
        chk("discard_req", 32'(bus.imem_req), 32'd1);
        chk("discard_addr", 32'(bus.imem_addr), 32'd2);
        chk("discard_misalign", 32'(bus.misalign_err), 32'd0);
        drv(1'b1, 1'b0, 32'h0, 1'b1);
        chk("discard_valid", 32'(bus.inst_valid), 32'd0);
        drv(1'b1, 1'b0, 32'h0, 1'b1);
        chk("target_addr", 32'(bus.imem_addr), 32'd16);
        chk("target_valid", 32'(bus.inst_valid), 32'd0);
        drv(1'b0, 1'b0, 32'h0, 1'b1);
        chk("target_out", 32'(bus.inst_valid), 32'd1);
        chk("sb_empty3", 32'(q.size()), 32'd0);

        // misaligned redirect squashes a stalled instruction
        do_reset();
        push(32'h20, 32'h1000_0008);
        drv(1'b1, 1'b0, 32'h0, 1'b0);
        drv(1'b0, 1'b1, 32'h22, 1'b0);
        chk("squash_pre_valid", 32'(bus.inst_valid), 32'd1);
        drv(1'b0, 1'b0, 32'h0, 1'b0);
        chk("squash_valid", 32'(bus.inst_valid), 32'd0);
        chk("misalign_pulse", 32'(bus.misalign_err), 32'd1);
        chk("squash_addr", 32'(bus.imem_addr), 32'd8);
        drv(1'b1, 1'b0, 32'h0, 1'b0);
        chk("misalign_once", 32'(bus.misalign_err), 32'd0);
        drv(1'b0, 1'b0, 32'h0, 1'b1);
        chk("sb_empty4", 32'(q.size()), 32'd0);

        // redirect coinciding with ack or ready in each state
        do_reset();
        push(32'h60, 32'h1000_0018);
        push(32'h10, 32'h1000_0004);
        push(32'h44, 32'h1000_0011);
        drv(1'b1, 1'b1, 32'h60, 1'b1);
        drv(1'b1, 1'b0, 32'h0, 1'b1);
        chk("fa_addr", 32'(bus.imem_addr), 32'd24);
        chk("fa_valid", 32'(bus.inst_valid), 32'd0);
        drv(1'b0, 1'b1, 32'h10, 1'b1);
        drv(1'b1, 1'b0, 32'h0, 1'b1);
        chk("or_addr", 32'(bus.imem_addr), 32'd4);
        chk("or_valid", 32'(bus.inst_valid), 32'd0);
        drv(1'b0, 1'b0, 32'h0, 1'b1);
        drv(1'b0, 1'b1, 32'h30, 1'b1);
        chk("fr_addr", 32'(bus.imem_addr), 32'd5);
        drv(1'b0, 1'b1, 32'h38, 1'b1);
        chk("dr_addr", 32'(bus.imem_addr), 32'd5);
        drv(1'b1, 1'b1, 32'h44, 1'b1);
        chk("da_addr", 32'(bus.imem_addr), 32'd5);
        drv(1'b0, 1'b0, 32'h0, 1'b1);
        chk("da_next_addr", 32'(bus.imem_addr), 32'd17);
        chk("da_valid", 32'(bus.inst_valid), 32'd0);
        drv(1'b1, 1'b0, 32'h0, 1'b1);
        drv(1'b0, 1'b0, 32'h0, 1'b1);
        chk("sb_empty5", 32'(q.size()), 32'd0);

        // reset while a stale request is being discarded
        do_reset();
        drv(1'b0, 1'b1, 32'h50, 1'b1);
        drv(1'b0, 1'b0, 32'h0, 1'b1);
        chk("pre_rst_addr", 32'(bus.imem_addr), 32'd0);
        chk("pre_rst_req", 32'(bus.imem_req), 32'd1);
        do_reset();
        push(32'h0, 32'h1000_0000);
        drv(1'b1, 1'b0, 32'h0, 1'b1);
        chk("restart_req", 32'(bus.imem_req), 32'd1);
        chk("restart_addr", 32'(bus.imem_addr), 32'd0);
        drv(1'b0, 1'b0, 32'h0, 1'b1);
        chk("sb_empty6", 32'(q.size()), 32'd0);

        do_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the single-cycle datapath.
- Owns the program counter and issues word requests to instruction memory over a req/ack handshake with variable latency.
- Presents each fetched instruction and its PC to the datapath over a valid/ready handshake.
- Handles redirects (branch/jump targets) from the datapath, including redirects that arrive while a memory request is in flight.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_AW, 5, instruction-memory word-address width; imem_addr = fetch address bits [IMEM_AW+1:2].

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- imem_req  output  1  memory request; held high until imem_ack.
- imem_addr  output  IMEM_AW  word address of the outstanding request; stable while imem_req=1.
- imem_ack  input  1  one-cycle pulse; imem_data valid in the same cycle; honoured only when imem_req=1.
- imem_data  input  32  instruction word returned by memory.
- redirect_valid  input  1  one-cycle request to restart fetch at redirect_pc.
- redirect_pc  input  32  redirect target.
- inst_valid  output  1  inst_data and inst_pc are valid.
- inst_data  output  32  fetched instruction.
- inst_pc  output  32  byte address of inst_data.
- inst_ready  input  1  datapath accepts the instruction when inst_valid=1 and inst_ready=1.
- misalign_err  output  1  one-cycle pulse when a redirect target has redirect_pc[1:0]!=0.

Behaviour:
Registers:
- pc (next fetch address).
- req_addr (address of the outstanding request).
- inst_data and inst_pc.
- state in {FETCH, OUT, DISCARD}.

Reset (rst=1 at an edge):
- pc=RESET_PC, state=FETCH.
- imem_req=0, inst_valid=0, inst_data=0, inst_pc=0, misalign_err=0.
- imem_req stays low in every cycle rst is high.
- First cycle after reset releases: imem_req=1, imem_addr=RESET_PC[IMEM_AW+1:2].

FETCH:
- imem_req=1, req_addr=pc.
- ack and no redirect: inst_data<=imem_data, inst_pc<=pc, pc<=pc+4, go to OUT.
- redirect and no ack: pc<=target, go to DISCARD. The original request stays asserted at its original address until it is acked.
- redirect and ack in the same cycle: drop the data, pc<=target, stay in FETCH. The next cycle requests the target.

DISCARD:
- imem_req=1 at the stale req_addr.
- On ack: drop the data, go to FETCH (fetch pc).
- A further redirect overwrites pc and keeps the state, or goes to FETCH if ack arrives in the same cycle.

OUT:
- inst_valid=1, imem_req=0.
- inst_data and inst_pc are held stable while not accepted.
- inst_ready=1: transfer completes, go to FETCH.
- Redirect without ready: instruction is squashed, inst_valid=0 next cycle, pc<=target, go to FETCH.
- Redirect with ready in the same cycle: transfer counts, pc<=target, go to FETCH.

Redirect target handling:
- target = {redirect_pc[31:2], 2'b00}.
- misalign_err=1 in the cycle after any redirect with nonzero low bits.

Arithmetic:
- pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
- imem_addr truncates to IMEM_AW bits, so fetches wrap across memory.

Timing:
- Latency: with ack in the first request cycle, inst_valid rises one cycle after imem_req rises.
- Peak throughput: one instruction per 2 cycles.

Reset mid-operation:
- Any outstanding request or valid instruction is abandoned.
- A late imem_ack after reset is ignored unless imem_req=1, and imem_req=1 only for the new RESET_PC request.

Test Plan:
- Reset with RESET_PC=0, ack every request cycle, inst_ready=1, memory word n = 32'h1000_0000+n -> inst_pc 0,4,8,... with matching inst_data, inst_valid every other cycle.
- Ack delayed 3 cycles, inst_ready low for 4 cycles in OUT -> imem_addr stable while waiting, inst_data/inst_pc constant while stalled, no duplicate or lost instruction.
- Redirect to 32'h40 one cycle after request to addr 8, ack 2 cycles later -> that data dropped, next request addr word 16, inst_pc=32'h40, no inst_valid for addr 8.
- Redirect to 32'h22 while in OUT with inst_ready=0 -> inst_valid drops, misalign_err pulses once, next inst_pc=32'h20.
- Redirect and inst_ready and ack coincidences (each pairing) -> transfer/drop per the rules above.
- RESET_PC=32'hFFFF_FFFC -> second inst_pc=0.
- rst asserted during DISCARD -> imem_req=0 while rst is high, then fetch restarts at RESET_PC.
